// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared states, opcodes and datapath select encodings for multicycle_ctrl
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUREG = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALUOUT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - funct3/funct7b5 to ALU operation decode with illegal flag
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [1:0] alu_ctrl,
  output logic       illegal
);

  // Bit 30 only selects subtract for register-register ops; addi ignores it.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct3)
      3'b000:  alu_ctrl = ((op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V control FSM
// MULTICYCLE_CTRL_MEM_WAIT_EN: honour mem_ready and the WAIT_MAX watchdog; otherwise memory is single-cycle.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic       err
);

  state_t     state_q, state_d, fsm_next;
  logic [1:0] dec_alu_ctrl;
  logic       dec_illegal;
  logic       mem_ready_eff;

  alu_decoder u_alu_decoder (
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (dec_alu_ctrl),
    .illegal  (dec_illegal)
  );

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic [7:0] wait_q, wait_d;
  logic       mem_access;
  logic       timeout;

  assign mem_ready_eff = mem_ready;
  assign mem_access    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // A late mem_ready on the limit cycle still completes the access normally.
  assign timeout       = mem_access && !mem_ready && (wait_q == 8'(WAIT_MAX));
  assign state_d       = timeout ? S_ERROR : fsm_next;

  always_comb begin
    wait_d = 8'd0;
    if ((state_d == state_q) && mem_access && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic       unused_mem_ready;
  logic [7:0] unused_wait_max;

  assign mem_ready_eff    = 1'b1;
  assign state_d          = fsm_next;
  assign unused_mem_ready = mem_ready;
  assign unused_wait_max  = 8'(WAIT_MAX);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_next   = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    imm_src    = IMM_I;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALUREG;
    err        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        ir_we      = mem_ready_eff;
        pc_we      = mem_ready_eff;
        if (mem_ready_eff) fsm_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: fsm_next = S_MEMADR;
          OP_RTYPE:          fsm_next = S_EXECR;
          OP_ITYPE:          fsm_next = S_EXECI;
          OP_BRANCH:         fsm_next = S_BEQ;
          default:           fsm_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        fsm_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready_eff) fsm_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_we     = 1'b1;
        fsm_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready_eff) fsm_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
        alu_ctrl  = dec_alu_ctrl;
        fsm_next  = dec_illegal ? S_ERROR : S_ALUWB;
      end
      S_ALUWB: begin
        reg_we   = 1'b1;
        fsm_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_ctrl  = ALU_SUB;
        if (funct3 == 3'b000) begin
          pc_we    = zero;
          fsm_next = S_FETCH;
        end else begin
          fsm_next = S_ERROR;
        end
      end
      S_ERROR: err = 1'b1;
      default: fsm_next = S_ERROR;
    endcase
    // While reset is held FETCH selects stay visible but nothing is loaded or requested.
    if (!rst) begin
      mem_req = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

  localparam int WMAX = 4;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, err;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src;
  logic [16:0] got;

  typedef struct {
    logic [16:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic       c_f7, c_zero;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .result_src (result_src),
    .err        (err)
  );

  assign got = {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
                imm_src, alu_src_a, alu_src_b, alu_ctrl, result_src, err};

  // Control word in the same field order as 'got'
  function automatic logic [16:0] cw(input logic mreq, input logic mwe, input logic adr,
                                     input logic irwe, input logic pcwe, input logic regwe,
                                     input logic [1:0] imm, input logic [1:0] sa,
                                     input logic [1:0] sbs, input logic [1:0] alu,
                                     input logic [1:0] res, input logic er);
    return {mreq, mwe, adr, irwe, pcwe, regwe, imm, sa, sbs, alu, res, er};
  endfunction

  function automatic logic [16:0] fetch_w(input logic rdy);
    return cw(1, 0, 0, rdy, rdy, 0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 0);
  endfunction
  function automatic logic [16:0] decode_w();
    return cw(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 0);
  endfunction
  function automatic logic [16:0] memadr_w(input logic store);
    return cw(0, 0, 0, 0, 0, 0, store ? 2'd1 : 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 0);
  endfunction
  function automatic logic [16:0] memread_w();
    return cw(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction
  function automatic logic [16:0] memwb_w();
    return cw(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 0);
  endfunction
  function automatic logic [16:0] memwrite_w();
    return cw(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction
  function automatic logic [1:0] alu_of(input logic r, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (r && f7) ? 2'd1 : 2'd0;
    if (f3 == 3'b110) return 2'd3;
    if (f3 == 3'b111) return 2'd2;
    return 2'd0;
  endfunction
  function automatic logic [16:0] exec_w(input logic r, input logic [2:0] f3, input logic f7);
    return cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, r ? 2'd0 : 2'd1, alu_of(r, f3, f7), 2'd0, 0);
  endfunction
  function automatic logic [16:0] aluwb_w();
    return cw(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
  endfunction
  function automatic logic [16:0] beq_w(input logic [2:0] f3, input logic z);
    return cw(0, 0, 0, 0, (f3 == 3'b000) && z, 0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 0);
  endfunction
  function automatic logic [16:0] err_w();
    return cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1);
  endfunction
  function automatic logic [16:0] rst_w();
    return cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 0);
  endfunction
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [16:0] e, input string tag);
    exp_t x;
    x.v   = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic drive(input logic rdy);
    op        = c_op;
    funct3    = c_f3;
    funct7b5  = c_f7;
    zero      = c_zero;
    mem_ready = rdy;
  endtask

  task automatic step(input logic rv, input logic rdy, input logic [16:0] e, input string tag);
    @(posedge clk);
    #1;
    rst = rv;
    drive(rdy);
    push(e, tag);
  endtask

  // Reset lands mid-cycle, so that same cycle must already show reset outputs
  task automatic reset_now(input string tag);
    @(posedge clk);
    #1;
    drive(1'b0);
    #1;
    rst = 1'b0;
    push(rst_w(), {tag, ".rst"});
    step(0, rnd(), rst_w(), {tag, ".rst_hold"});
  endtask

  task automatic error_reset(input string tag);
    repeat (3) begin
      c_op = 7'($urandom);
      c_f3 = 3'($urandom);
      step(1, rnd(), err_w(), {tag, ".err"});
    end
    reset_now(tag);
  endtask

  task automatic mem_phase(input logic [16:0] ew, input logic [16:0] ed, input int w,
                           input string tag, output bit to);
    to = 1'b0;
    if (WAIT_EN) begin
      for (int i = 0; i < w; i++) begin
        step(1, 0, ew, tag);
        if (i == WMAX) begin
          to = 1'b1;
          return;
        end
      end
      step(1, 1, ed, tag);
    end else begin
      step(1, rnd(), ed, tag);
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw, input string tag);
    bit to;
    c_op = o; c_f3 = f3; c_f7 = f7; c_zero = z;
    mem_phase(fetch_w(0), fetch_w(1), fw, {tag, ".fetch"}, to);
    if (to) begin
      error_reset(tag);
      return;
    end
    step(1, rnd(), decode_w(), {tag, ".decode"});
    case (o)
      LW, SW: begin
        step(1, rnd(), memadr_w(o == SW), {tag, ".memadr"});
        if (o == SW) begin
          mem_phase(memwrite_w(), memwrite_w(), mw, {tag, ".memwrite"}, to);
          if (to) error_reset(tag);
        end else begin
          mem_phase(memread_w(), memread_w(), mw, {tag, ".memread"}, to);
          if (to) error_reset(tag);
          else step(1, rnd(), memwb_w(), {tag, ".memwb"});
        end
      end
      RT, IT: begin
        step(1, rnd(), exec_w(o == RT, f3, f7), {tag, ".exec"});
        if (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111) step(1, rnd(), aluwb_w(), {tag, ".aluwb"});
        else error_reset(tag);
      end
      BR: begin
        step(1, rnd(), beq_w(f3, z), {tag, ".beq"});
        if (f3 != 3'b000) error_reset(tag);
      end
      default: error_reset(tag);
    endcase
  endtask

  task automatic lw_abort(input string tag);
    bit to;
    c_op = LW; c_f3 = 3'b010; c_f7 = 1'b0; c_zero = 1'b0;
    mem_phase(fetch_w(0), fetch_w(1), 0, {tag, ".fetch"}, to);
    step(1, rnd(), decode_w(), {tag, ".decode"});
    step(1, rnd(), memadr_w(0), {tag, ".memadr"});
    reset_now({tag, ".memread"});
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h at %0t", e.tag, got, e.v, $time);
      end
    end
  end

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    int         k;
    rst = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    c_op = '0; c_f3 = '0; c_f7 = 1'b0; c_zero = 1'b0;
    step(0, 1, rst_w(), "reset");
    step(0, 1, rst_w(), "reset");

    run_instr(LW, 3'b010, 0, 0, 0, 0, "lw");
    run_instr(BR, 3'b000, 0, 1, 0, 0, "beq_taken");
    run_instr(BR, 3'b000, 0, 0, 0, 0, "beq_not");
    run_instr(RT, 3'b000, 1, 0, 0, 0, "sub");
    run_instr(SW, 3'b010, 0, 0, 0, 3, "sw_wait3");
    run_instr(RT, 3'b001, 0, 0, 0, 0, "r_f3_001");
    lw_abort("lw_abort");
    run_instr(IT, 3'b110, 1, 0, 2, 0, "ori");
    run_instr(BR, 3'b001, 0, 1, 0, 0, "bne_illegal");

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 11);
      case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b110;
        2: f3 = 3'b111;
        default: f3 = 3'($urandom);
      endcase
      case (k)
        0, 1: o = LW;
        2, 3: o = SW;
        4, 5: o = RT;
        6, 7: o = IT;
        8, 9: o = BR;
        default: begin
          o = 7'($urandom);
          if (o == LW || o == SW || o == RT || o == IT || o == BR) o = 7'b1111111;
        end
      endcase
      if (k == 11) lw_abort($sformatf("rnd%0d_abort", n));
      else run_instr(o, f3, rnd(), rnd(), $urandom_range(0, WMAX), $urandom_range(0, WMAX),
                     $sformatf("rnd%0d", n));
    end

    run_instr(LW, 3'b010, 0, 0, WMAX + 1, 0, "fetch_timeout");
    run_instr(SW, 3'b010, 0, 0, 0, WMAX + 1, "sw_timeout");
    run_instr(LW, 3'b010, 0, 0, WMAX, WMAX, "wait_limit");
    run_instr(RT, 3'b111, 0, 0, 0, 0, "and_final");

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum memory wait cycles before error (1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op  input  7  instruction opcode bits [6:0] from the instruction register.
REQ-005 SHALL have port funct3  input  3  instruction bits [14:12].
REQ-006 SHALL have port funct7b5  input  1  instruction bit 30.
REQ-007 SHALL have port zero  input  1  ALU zero flag.
REQ-008 SHALL have port mem_ready  input  1  memory completed the current access.
REQ-009 SHALL have port mem_req  output  1  memory access request.
REQ-010 SHALL have port mem_we  output  1  memory write enable.
REQ-011 SHALL have port adr_src  output  1  address source: 0 = pc, 1 = ALU result register.
REQ-012 SHALL have port ir_we  output  1  instruction and old-pc register load.
REQ-013 SHALL have port pc_we  output  1  pc register load.
REQ-014 SHALL have port reg_we  output  1  register file write enable.
REQ-015 SHALL have port imm_src  output  2  immediate type: 0 = I, 1 = S, 2 = B.
REQ-016 SHALL have port alu_src_a  output  2  ALU operand A: 0 = pc, 1 = old pc, 2 = rs1.
REQ-017 SHALL have port alu_src_b  output  2  ALU operand B: 0 = rs2, 1 = immediate, 2 = constant 4.
REQ-018 SHALL have port alu_ctrl  output  2  ALU operation: 0 = add, 1 = sub, 2 = and, 3 = or.
REQ-019 SHALL have port result_src  output  2  result source: 0 = ALU result register, 1 = data register, 2 = ALU output.
REQ-020 SHALL have port err  output  1  sticky error flag.

Function
REQ-021 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and ERROR. The only exceptions are pc_we in FETCH/BEQ and ir_we in FETCH, which are gated by inputs.
REQ-022 SHALL default every output to 0 in any state that does not drive it.
REQ-023 In FETCH, SHALL drive mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_ctrl=add and result_src=2. SHALL drive ir_we=pc_we=mem_ready. SHALL move to DECODE on mem_ready, otherwise remain in FETCH.
REQ-024 In DECODE, SHALL drive alu_src_a=1, alu_src_b=1, imm_src=B and alu_ctrl=add (precomputes the branch target). SHALL transition on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- any other value -> ERROR
REQ-025 In MEMADR, SHALL drive alu_src_a=2, alu_src_b=1 and alu_ctrl=add. SHALL drive imm_src=S if op=0100011, else I. SHALL then go to MEMWRITE (store) or MEMREAD (load).
REQ-026 In MEMREAD, SHALL drive mem_req=1 and adr_src=1. SHALL go to MEMWB on mem_ready, otherwise hold.
REQ-027 In MEMWB, SHALL drive result_src=1 and reg_we=1, then go to FETCH.
REQ-028 In MEMWRITE, SHALL drive mem_req=1, mem_we=1 and adr_src=1. SHALL go to FETCH on mem_ready, otherwise hold.
REQ-029 In EXECR and EXECI, SHALL drive alu_src_a=2. SHALL drive alu_src_b=0 in EXECR, and alu_src_b=1 with imm_src=I in EXECI. Both states SHALL then go to ALUWB.
REQ-030 SHALL decode alu_ctrl in EXECR/EXECI from funct3:
- 000 -> add, or sub when EXECR and funct7b5=1
- 110 -> or
- 111 -> and
- any other funct3 -> ERROR next cycle
REQ-031 In ALUWB, SHALL drive result_src=0 and reg_we=1, then go to FETCH.
REQ-032 In BEQ, SHALL drive alu_src_a=2, alu_src_b=0, alu_ctrl=sub, result_src=0 and pc_we=zero, then go to FETCH. A funct3 other than 000 SHALL go to ERROR with pc_we=0.
REQ-033 SHALL count consecutive cycles spent waiting (mem_req=1, mem_ready=0) with an 8-bit counter. The counter SHALL clear when the state changes.
REQ-034 When the wait counter reaches WAIT_MAX without mem_ready, SHALL enter ERROR on the next edge. If mem_ready arrives on that same cycle, the normal transition SHALL win.
REQ-035 ERROR SHALL drive err=1 with all other outputs 0, and SHALL be exited only by reset.

Reset
REQ-036 When rst=0, SHALL immediately force state=FETCH, wait counter=0 and err=0. FETCH outputs apply while reset is held, except that pc_we, ir_we and mem_req SHALL be forced to 0.
REQ-037 Reset asserted mid-operation (any state, including ERROR or a mid-wait) SHALL abandon the instruction without any further reg_we or mem_we.
REQ-038 The first FETCH access SHALL begin on the first rising edge after rst deasserts.

Configuration
REQ-039 With MULTICYCLE_CTRL_MEM_WAIT_EN defined, SHALL honour mem_ready and the WAIT_MAX watchdog as specified.
REQ-040 Without MULTICYCLE_CTRL_MEM_WAIT_EN, SHALL treat mem_ready as constant 1: every memory state lasts one cycle, and the wait counter and timeout logic are not built.

Structure
REQ-041 The shared package SHALL hold:
- the state enum
- opcode constants
- alu_ctrl, imm_src, alu_src_a, alu_src_b and result_src encodings
REQ-042 ALU control decode SHALL live in one combinational sub-module, alu_decoder(op, funct3, funct7b5 -> alu_ctrl, illegal).

Verification
REQ-043 Test lw (op=0000011) with mem_ready=1: states SHALL follow FETCH,DECODE,MEMADR,MEMREAD,MEMWB over 5 cycles, with reg_we=1 and result_src=1 only in cycle 5.
REQ-044 Test beq (funct3=000) with zero=1: pc_we=1 SHALL occur in BEQ. With zero=0, pc_we=0 SHALL hold in BEQ and FETCH SHALL follow.
REQ-045 Test R-type funct3=000, funct7b5=1: EXECR SHALL show alu_ctrl=1. Test funct3=001: the next state SHALL be ERROR, with err=1 sticky until rst=0.
REQ-046 Test sw with mem_ready held low 3 cycles in MEMWRITE: mem_we SHALL stay 1 for 4 cycles, then FETCH follows.
REQ-047 With WAIT_MAX=4 and mem_ready never asserted in FETCH, err SHALL rise after 5 cycles. The same stimulus without the macro SHALL reach DECODE in 1 cycle.
REQ-048 Assert rst=0 in MEMREAD: outputs SHALL go to their reset values asynchronously, and state SHALL be FETCH after release.
